// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch flushes, dmem waits.
// Controls are combinational (same-cycle) from FSM state and inputs; state and perf counters are registered.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_busy;
  logic       load_use;

  assign mem_busy = (exmem_mem_read | exmem_mem_write) & ~dmem_ready;
  assign load_use = idex_mem_read & (idex_rt != 5'd0) &
                    ((idex_rt == id_rs) | (idex_rt == id_rt));

  // RUN and MEM_WAIT share one rule set: a wait releases in the cycle dmem_ready rises.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            pipe_hold = 1'b1;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        FAULT:   pipe_hold = 1'b1;
        default: pipe_hold = 1'b0;
      endcase
    end
  end

  always_comb begin
    forward_a = 2'b00;
    if (rst) begin
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_rs)
        forward_a = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_rs)
        forward_a = 2'b01;
    end
  end

  always_comb begin
    forward_b = 2'b00;
    if (rst) begin
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_rt)
        forward_b = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_rt)
        forward_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_fault <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_V) begin
            state     <= FAULT;
            mem_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase

      // FAULT is a dead pipeline, not a stall, so it is left out of the stall count.
      if (state != FAULT && !pc_write && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and CNT_W=3 so timeout and saturation are reachable.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             idex_mem_read, exmem_reg_write, memwb_reg_write;
  logic             exmem_mem_read, exmem_mem_write, dmem_ready, branch_taken;
  logic [4:0]       idex_rt, id_rs, id_rt, ex_rs, ex_rt, exmem_rd, memwb_rd;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
  logic [1:0]       forward_a, forward_b;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [5:0]       ctl;
  int               errors = 0;
  int               checks = 0;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold}
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .forward_a(forward_a), .forward_b(forward_b), .mem_fault(mem_fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clear_inputs();
    idex_mem_read = 0; exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_mem_read = 0; exmem_mem_write = 0; dmem_ready = 0; branch_taken = 0;
    idex_rt = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    branch_taken = 1; exmem_mem_read = 1; exmem_reg_write = 1;
    exmem_rd = 7; ex_rs = 7; ex_rt = 7; idex_mem_read = 1; idex_rt = 7; id_rs = 7;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {forward_a, forward_b}); end
    checks++; if ({mem_fault, stall_cnt, flush_cnt} !== 7'd0) begin errors++; $display("FAIL reset_regs: got fault=%0d stall=%0d flush=%0d expected 0", mem_fault, stall_cnt, flush_cnt); end
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL reset_release_ctl: got %b expected 110000", ctl); end
  endtask

  task automatic test_load_use();
    pulse_reset();
    next_cycle(); idex_mem_read = 1; idex_rt = 5; id_rs = 5;
    @(negedge clk);
    checks++; if (ctl !== 6'b000100) begin errors++; $display("FAIL load_use_rs: got %b expected 000100", ctl); end
    next_cycle(); clear_inputs();
    @(negedge clk);
    checks++; if (ctl !== 6'b110000 || stall_cnt !== 3'd1) begin errors++; $display("FAIL load_use_after: got ctl=%b stall=%0d expected 110000 stall=1", ctl, stall_cnt); end
    next_cycle(); idex_mem_read = 1; idex_rt = 9; id_rs = 5; id_rt = 9;
    @(negedge clk);
    checks++; if (ctl !== 6'b000100) begin errors++; $display("FAIL load_use_rt: got %b expected 000100", ctl); end
    next_cycle(); idex_rt = 0; id_rs = 0; id_rt = 0;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000 || stall_cnt !== 3'd2) begin errors++; $display("FAIL load_use_r0: got ctl=%b stall=%0d expected 110000 stall=2", ctl, stall_cnt); end
    next_cycle(); idex_mem_read = 0; idex_rt = 5; id_rs = 5;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000 || stall_cnt !== 3'd2) begin errors++; $display("FAIL load_use_noload: got ctl=%b stall=%0d expected 110000 stall=2", ctl, stall_cnt); end
  endtask

  task automatic test_branch();
    pulse_reset();
    next_cycle(); branch_taken = 1; idex_mem_read = 1; idex_rt = 3; id_rs = 3;
    @(negedge clk);
    checks++; if (ctl !== 6'b111110) begin errors++; $display("FAIL branch_ctl: got %b expected 111110", ctl); end
    next_cycle(); clear_inputs();
    @(negedge clk);
    checks++; if (flush_cnt !== 3'd1 || stall_cnt !== 3'd0) begin errors++; $display("FAIL branch_cnt: got flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    next_cycle(); exmem_mem_read = 1; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL mem_wait_c1: got %b expected 000001", ctl); end
    next_cycle(); idex_mem_read = 1; idex_rt = 2; id_rs = 2;
    @(negedge clk);
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL mem_wait_c2: got %b expected 000001", ctl); end
    next_cycle();
    @(negedge clk);
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL mem_wait_c3: got %b expected 000001", ctl); end
    next_cycle(); dmem_ready = 1; idex_mem_read = 0;
    @(negedge clk);
    checks++; if (ctl !== 6'b111110) begin errors++; $display("FAIL mem_wait_release_branch: got %b expected 111110", ctl); end
    next_cycle(); clear_inputs();
    @(negedge clk);
    checks++; if ({mem_fault, stall_cnt, flush_cnt} !== {1'b0, 3'd3, 3'd1}) begin errors++; $display("FAIL mem_wait_cnt: got fault=%0d stall=%0d flush=%0d expected 0 3 1", mem_fault, stall_cnt, flush_cnt); end
    next_cycle(); exmem_mem_write = 1;
    @(negedge clk);
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL mem_wait_store: got %b expected 000001", ctl); end
    next_cycle(); dmem_ready = 1;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL mem_wait_release_plain: got %b expected 110000", ctl); end
    next_cycle(); exmem_mem_write = 0; exmem_mem_read = 1; dmem_ready = 1;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000 || stall_cnt !== 3'd4) begin errors++; $display("FAIL mem_ready_now: got ctl=%b stall=%0d expected 110000 stall=4", ctl, stall_cnt); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    next_cycle(); exmem_mem_write = 1; dmem_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if ({ctl, mem_fault} !== 7'b0000010) begin errors++; $display("FAIL timeout_wait%0d: got ctl=%b fault=%b expected 000001 0", i, ctl, mem_fault); end
      next_cycle();
    end
    exmem_mem_write = 0; dmem_ready = 1;
    @(negedge clk);
    checks++; if ({ctl, mem_fault} !== 7'b0000011) begin errors++; $display("FAIL timeout_fault: got ctl=%b fault=%b expected 000001 1", ctl, mem_fault); end
    checks++; if (stall_cnt !== 3'd5) begin errors++; $display("FAIL timeout_stall: got %0d expected 5", stall_cnt); end
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (ctl !== 6'b000001 || stall_cnt !== 3'd5) begin errors++; $display("FAIL fault_sticky: got ctl=%b stall=%0d expected 000001 stall=5", ctl, stall_cnt); end
    next_cycle(); rst = 1'b0;
    #1;
    checks++; if ({ctl, mem_fault, stall_cnt} !== 10'd0) begin errors++; $display("FAIL fault_reset: got ctl=%b fault=%b stall=%0d expected all 0", ctl, mem_fault, stall_cnt); end
    next_cycle(); rst = 1'b1; clear_inputs();
    @(negedge clk);
    checks++; if ({ctl, mem_fault, flush_cnt} !== {6'b110000, 1'b0, 3'd0}) begin errors++; $display("FAIL fault_recover: got ctl=%b fault=%b flush=%0d expected 110000 0 0", ctl, mem_fault, flush_cnt); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    exmem_reg_write = 1; exmem_rd = 7; memwb_reg_write = 1; memwb_rd = 7; ex_rs = 7; ex_rt = 7;
    #1;
    checks++; if ({forward_a, forward_b} !== 4'b1010) begin errors++; $display("FAIL fwd_exmem_prio: got %b expected 1010", {forward_a, forward_b}); end
    exmem_reg_write = 0;
    #1;
    checks++; if ({forward_a, forward_b} !== 4'b0101) begin errors++; $display("FAIL fwd_memwb: got %b expected 0101", {forward_a, forward_b}); end
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; ex_rs = 0; ex_rt = 0;
    #1;
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin errors++; $display("FAIL fwd_r0: got %b expected 0000", {forward_a, forward_b}); end
    exmem_rd = 3; ex_rs = 3; memwb_rd = 4; ex_rt = 4;
    #1;
    checks++; if ({forward_a, forward_b} !== 4'b1001) begin errors++; $display("FAIL fwd_split: got %b expected 1001", {forward_a, forward_b}); end
    memwb_reg_write = 0;
    #1;
    checks++; if ({forward_a, forward_b} !== 4'b1000) begin errors++; $display("FAIL fwd_nowrite: got %b expected 1000", {forward_a, forward_b}); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    pulse_reset();
    next_cycle(); idex_mem_read = 1; idex_rt = 5; id_rs = 5;
    repeat (6) next_cycle();
    @(negedge clk);
    checks++; if (stall_cnt !== 3'd6) begin errors++; $display("FAIL sat_stall_mid: got %0d expected 6", stall_cnt); end
    repeat (4) next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_stall: got %0d expected 7", stall_cnt); end
    next_cycle(); branch_taken = 1;
    repeat (9) next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (flush_cnt !== 3'd7 || stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_flush: got flush=%0d stall=%0d expected 7 7", flush_cnt, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
